// File: rtl/crc_pkg.sv
// Shared CRC-16 constants, frame FSM encoding and a reference single-bit LFSR step.
// Used by the serial divider and the parallel CRC checker.
package crc_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CRC_W  = 16;
    localparam logic [CRC_W-1:0] POLY = 16'h8005;
    localparam int unsigned TOTAL  = DATA_W + CRC_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift the new bit in at the bottom; fold the generator back in when the
    // bit leaving the top (the implicit x^16 coefficient) was set.
    function automatic logic [CRC_W-1:0] lfsr_step(
        input logic [CRC_W-1:0] r,
        input logic             b,
        input logic [CRC_W-1:0] poly
    );
        logic [CRC_W-1:0] shifted;
        shifted = {r[CRC_W-2:0], b};
        return r[CRC_W-1] ? (shifted ^ poly) : shifted;
    endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// Combinational one-bit step of an augmented CRC long-division LFSR.
module crc_lfsr_step #(
    parameter int unsigned       CRC_W = crc_pkg::CRC_W,
    parameter logic [CRC_W-1:0] POLY  = crc_pkg::POLY
) (
    input  logic [CRC_W-1:0] r,
    input  logic             b,
    output logic [CRC_W-1:0] r_next
);

    logic [CRC_W-1:0] shifted;

    always_comb begin
        shifted = {r[CRC_W-2:0], b};
        r_next  = r[CRC_W-1] ? (shifted ^ POLY) : shifted;
    end

endmodule

// File: rtl/crc16_serial_div.sv
// Serial CRC-16 divider: collects DATA_W message bits plus CRC_W zero pad bits
// MSB-first and presents remainder, codeword and pad-error flag at frame end.
module crc16_serial_div
    import crc_pkg::*;
#(
    parameter int unsigned       DATA_W = crc_pkg::DATA_W,
    parameter int unsigned       CRC_W  = crc_pkg::CRC_W,
    parameter logic [CRC_W-1:0] POLY   = crc_pkg::POLY
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic                    Bit_en,
    input  logic                    Bit_in,
    output logic                    Busy,
    output logic                    Done,
    output logic [CRC_W-1:0]        Crc,
    output logic [DATA_W+CRC_W-1:0] Codeword,
    output logic                    Pad_err
);

    localparam int unsigned FRAME_LEN = DATA_W + CRC_W;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CRC_W-1:0]  r;
    logic [CRC_W-1:0]  r_next;
    logic [DATA_W-1:0] msg;
    logic              pad_err_q;
    logic              sample;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .r      (r),
        .b      (Bit_in),
        .r_next (r_next)
    );

    // Start wins over Bit_en, so a bit presented alongside Start is dropped.
    assign sample = (state == RUN) && Bit_en && !Start;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            r         <= '0;
            msg       <= '0;
            pad_err_q <= 1'b0;
        end else if (Start) begin
            state     <= RUN;
            cnt       <= '0;
            r         <= '0;
            msg       <= '0;
            pad_err_q <= 1'b0;
        end else if (sample) begin
            r   <= r_next;
            cnt <= cnt + 1'b1;
            if (cnt < CNT_W'(DATA_W)) begin
                msg <= {msg[DATA_W-2:0], Bit_in};
            end else if (Bit_in) begin
                pad_err_q <= 1'b1;
            end
            if (cnt == CNT_W'(FRAME_LEN - 1)) begin
                state <= DONE;
            end
        end
    end

    assign Busy     = (state == RUN);
    assign Done     = (state == DONE);
    assign Crc      = r;
    assign Codeword = {msg, r};
    assign Pad_err  = pad_err_q;

endmodule

// File: tb/tb_crc16_serial_div.sv
// Bench for crc16_serial_div: directed frames plus randomized frames checked
// against a polynomial-modulo reference.
module tb_crc16_serial_div;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Bit_en = 1'b0;
    logic        Bit_in = 1'b0;
    logic        Busy;
    logic        Done;
    logic [15:0] Crc;
    logic [19:0] Codeword;
    logic        Pad_err;

    int total = 0;
    int bad   = 0;

    crc16_serial_div dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Bit_en   (Bit_en),
        .Bit_in   (Bit_in),
        .Busy     (Busy),
        .Done     (Done),
        .Crc      (Crc),
        .Codeword (Codeword),
        .Pad_err  (Pad_err)
    );

    always #5 Clk = ~Clk;

    // Remainder of the 20-bit stream polynomial modulo x^16+x^15+x^2+1.
    function automatic logic [15:0] ref_crc(input logic [19:0] v);
        logic [19:0] t;
        logic [19:0] g;
        t = v;
        g = 20'h18005;
        for (int i = 19; i >= 16; i--) begin
            if (t[i]) t = t ^ (g << (i - 16));
        end
        return t[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic en, input logic b);
        @(negedge Clk);
        Start  = 1'b1;
        Bit_en = en;
        Bit_in = b;
    endtask

    task automatic send_bit(input logic b);
        @(negedge Clk);
        Start  = 1'b0;
        Bit_en = 1'b1;
        Bit_in = b;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            Start  = 1'b0;
            Bit_en = 1'b0;
            Bit_in = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input logic [3:0] m, input logic [15:0] pad,
                             input int gap_pos, input int gap_len, input logic start_en);
        logic [19:0] v;
        logic [15:0] exp_crc;
        v       = {m, pad};
        exp_crc = ref_crc(v);
        do_start(start_en, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i == gap_pos) idle(gap_len);
            send_bit(v[19 - i]);
            if (i == 19) begin
                chk({tag, ".done_early"}, 32'(Done), 32'd0);
                chk({tag, ".busy_last"}, 32'(Busy), 32'd1);
            end
        end
        idle(1);
        chk({tag, ".done"}, 32'(Done), 32'd1);
        chk({tag, ".busy"}, 32'(Busy), 32'd0);
        chk({tag, ".crc"}, 32'(Crc), 32'(exp_crc));
        chk({tag, ".codeword"}, 32'(Codeword), 32'({m, exp_crc}));
        chk({tag, ".pad_err"}, 32'(Pad_err), 32'(|pad));
    endtask

    initial begin
        logic [3:0]  rm;
        logic [15:0] rp;

        // Reset state
        #1;
        chk("rst.busy", 32'(Busy), 32'd0);
        chk("rst.done", 32'(Done), 32'd0);
        chk("rst.crc", 32'(Crc), 32'd0);
        chk("rst.codeword", 32'(Codeword), 32'd0);
        chk("rst.pad_err", 32'(Pad_err), 32'd0);
        idle(2);
        Reset = 1'b0;

        // Bit_en in IDLE is ignored
        send_bit(1'b1);
        send_bit(1'b1);
        idle(1);
        chk("idle.crc", 32'(Crc), 32'd0);
        chk("idle.busy", 32'(Busy), 32'd0);

        // Directed frames; first Start carries Bit_en=1 that must be dropped
        run_frame("m1011", 4'b1011, 16'h0000, -1, 0, 1'b1);
        chk("m1011.const", 32'(Crc), 32'h8039);
        chk("m1011.cw_const", 32'(Codeword), 32'hB8039);

        // Bit_en in DONE is ignored
        send_bit(1'b1);
        send_bit(1'b0);
        idle(1);
        chk("done_hold.crc", 32'(Crc), 32'h8039);
        chk("done_hold.done", 32'(Done), 32'd1);

        run_frame("m0000", 4'b0000, 16'h0000, -1, 0, 1'b0);
        run_frame("m0001", 4'b0001, 16'h0000, -1, 0, 1'b0);
        chk("m0001.const", 32'(Crc), 32'h8005);
        run_frame("m1000", 4'b1000, 16'h0000, -1, 0, 1'b0);
        chk("m1000.const", 32'(Crc), 32'h8033);

        // Stall of 3 cycles mid-stream
        run_frame("gap", 4'b1011, 16'h0000, 2, 3, 1'b0);
        chk("gap.const", 32'(Crc), 32'h8039);

        // 1 in pad bit 10, then Start clears Pad_err
        run_frame("pad", 4'b1011, 16'h0001 << (15 - 10), -1, 0, 1'b0);
        do_start(1'b0, 1'b0);
        idle(1);
        chk("pad.clr", 32'(Pad_err), 32'd0);
        chk("pad.clr_done", 32'(Done), 32'd0);
        chk("pad.clr_busy", 32'(Busy), 32'd1);
        chk("pad.clr_crc", 32'(Crc), 32'd0);

        // Asynchronous reset after 12 bits
        do_start(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) send_bit((i == 6) ? 1'b1 : 1'b0);
        idle(1);
        chk("mid.pad_pre", 32'(Pad_err), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("mid.busy", 32'(Busy), 32'd0);
        chk("mid.done", 32'(Done), 32'd0);
        chk("mid.crc", 32'(Crc), 32'd0);
        chk("mid.pad_err", 32'(Pad_err), 32'd0);
        idle(1);
        Reset = 1'b0;
        run_frame("post_rst", 4'b0001, 16'h0000, -1, 0, 1'b0);

        // Restart after 8 bits
        do_start(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(i[0]);
        chk("restart.busy", 32'(Busy), 32'd1);
        run_frame("restart", 4'b1011, 16'h0000, -1, 0, 1'b0);
        chk("restart.const", 32'(Crc), 32'h8039);

        // Randomized frames
        for (int n = 0; n < 8; n++) begin
            rm = 4'($urandom);
            rp = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0000;
            run_frame($sformatf("rnd%0d", n), rm, rp, int'($urandom_range(0, 25)),
                      int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc16_serial_div.md
# crc16_serial_div

Serial CRC-16 divider directly downstream of the 4-bit message shift register. It samples the MSB-first bit stream that the shift register produces: DATA_W message bits followed by CRC_W appended zero bits. It performs augmented polynomial long division with a 16-bit LFSR, then presents the remainder, the assembled codeword and a pad-error flag when the frame completes.

## Interface
- DATA_W, 4: message bits per frame.
- CRC_W, 16: remainder width.
- POLY, 16'h8005: generator x^16+x^15+x^2+1, implicit x^16 term.
- Clk  in  1: clock; all state updates on posedge.
- Reset  in  1: asynchronous, active-high; clears all state and outputs.
- Start  in  1: one-cycle pulse; clears the datapath and arms a new frame.
- Bit_en  in  1: qualifies Bit_in; tie to the shift register's load/enable.
- Bit_in  in  1: serial bit from the shift register's serial output, which changes on negedge Clk.
- Busy  out  1: high while a frame is being collected.
- Done  out  1: high from frame completion until the next Start or Reset.
- Crc  out  CRC_W: running remainder; final when Done=1.
- Codeword  out  DATA_W+CRC_W: {captured message, Crc}; meaningful when Done=1.
- Pad_err  out  1: sticky per frame; a 1 was sampled in the pad region.

## Operation
- TOTAL = DATA_W+CRC_W = 20. The bit counter is $clog2(TOTAL+1) = 5 bits wide, and its reset value is 0.
- FSM states are IDLE, RUN and DONE; the reset state is IDLE.
  - IDLE: Start → RUN.
  - RUN: the TOTAL-th sampled bit → DONE; Start → RUN (restart).
  - DONE: Start → RUN.
- Start in any state does all of the following at once:
  - clears the LFSR, the counter, the message register and Pad_err;
  - clears Done;
  - moves the FSM to RUN.
- Start has priority over Bit_en. A bit presented in the Start cycle is not sampled.
- Sample rule: a bit is consumed only on a posedge where state=RUN and Bit_en=1. Bit_en in IDLE or DONE is ignored.
- LFSR step per sampled bit b:
  - fb = r[15];
  - r = {r[14:0], b};
  - if fb, then r ^= POLY.
- After all TOTAL bits, r is the remainder of the message times x^16, modulo the generator.
- Message capture: the first DATA_W sampled bits are shifted MSB-first into the message register. Later bits do not affect it.
- Pad check: a sampled bit with count ≥ DATA_W that equals 1 sets Pad_err. Pad_err stays set until Start or Reset. The CRC is still computed normally.
- Crc always equals r. Codeword = {msg, r}.
- Reset values:
  - Busy=0, Done=0, Pad_err=0;
  - Crc=16'h0000;
  - Codeword=20'h00000.

## Timing
- Bit_in changes on negedge Clk and is sampled on the following posedge, giving half a cycle of setup.
- Start is asserted on the posedge at or before the one preceding the first valid bit. In practice this is the same cycle the upstream load asserts.
- Busy=1 on the cycle after the Start edge, through the edge that samples bit TOTAL.
- On the edge that samples bit TOTAL:
  - Busy falls;
  - Done rises;
  - Crc and Codeword hold final values.
- Latency from first sampled bit to Done is TOTAL edges. There is no extra pipeline stage.
- Gaps in Bit_en stall the frame. Counter and LFSR hold.
- Reset asserted mid-frame: all outputs clear immediately (asynchronously) and the FSM enters IDLE. The partial frame is discarded.
- Start while RUN aborts and restarts the frame. No Done is produced for the aborted frame.

## Structure
- Shared package crc_pkg holds:
  - the DATA_W, CRC_W, POLY and TOTAL constants;
  - the state enum {IDLE, RUN, DONE};
  - a function computing one LFSR step.
- Sub-module crc_lfsr_step is combinational: (r, b) → r_next, parameterised by POLY. It is reused by the parallel CRC checker.
- The top level holds the FSM, the counter, the message register, the Pad_err flag and the LFSR register.

## Test plan
- Message 1011, then 16 zeros with Bit_en held high → Done after 20 sampled bits; Crc=16'h8039; Codeword=20'hB8039; Pad_err=0.
- Frame-boundary messages, each followed by 16 zero pad bits:
  - 0000 → Crc=16'h0000;
  - 0001 → Crc=16'h8005;
  - 1000 → Crc=16'h8033.
- Message 1011 with Bit_en deasserted for 3 cycles mid-stream → identical result: 16'h8039, with Done 3 cycles later.
- Message 1011 with a 1 in pad bit 10 → Done=1 and Pad_err=1. Next Start clears Pad_err.
- Reset pulsed after 12 bits → Busy, Done, Crc and Pad_err all 0 immediately. A new full frame of 0001 then gives 16'h8005.
- Start after 8 bits (restart), then a full 1011 frame → exactly one Done with Crc=16'h8039. Start coincident with Bit_en=1 in IDLE → that bit is not counted.
